// File: rtl/morse_key_timer.sv
// Morse front end: synchronizes and debounces the key, times each press,
// emits one-cycle dot (S) / dash (L) pulses on release, and raises T after
// a long idle gap.
module morse_key_timer #(
  parameter int unsigned CNT_W     = 27,
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DOT_MAX   = 25000000,
  parameter int unsigned T_LIMIT   = 75000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Key,
  input  logic Tclear,
  output logic S,
  output logic L,
  output logic T,
  output logic KeyHeld
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] T_LIM   = CNT_W'(T_LIMIT);

  typedef enum logic {UP, DOWN} state_t;

  logic             k1, k2;
  logic             KeyClean;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] press_cnt, press_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             s_nxt, l_nxt;
  state_t           state, state_nxt;

  // Two-flop synchronizer for the asynchronous key input.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      k1 <= 1'b0;
      k2 <= 1'b0;
    end else begin
      k1 <= Key;
      k2 <= k1;
    end
  end

  // Accept a new key level only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      KeyClean <= 1'b0;
      db_cnt   <= '0;
    end else if (k2 == KeyClean) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      KeyClean <= k2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign KeyHeld = KeyClean;

  // Press FSM state, press length and registered pulse outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= UP;
      press_cnt <= '0;
      S         <= 1'b0;
      L         <= 1'b0;
    end else begin
      state     <= state_nxt;
      press_cnt <= press_nxt;
      S         <= s_nxt;
      L         <= l_nxt;
    end
  end

  // Next-state logic: count while held, classify the press on release.
  always_comb begin
    state_nxt = state;
    press_nxt = press_cnt;
    s_nxt     = 1'b0;
    l_nxt     = 1'b0;
    case (state)
      UP: begin
        if (KeyClean) begin
          state_nxt = DOWN;
          press_nxt = CNT_W'(1);
        end
      end
      DOWN: begin
        if (KeyClean) begin
          if (press_cnt != '1) press_nxt = press_cnt + 1'b1;
        end else begin
          state_nxt = UP;
          if (press_cnt <= DOT_LIM) s_nxt = 1'b1;
          else                      l_nxt = 1'b1;
        end
      end
      default: state_nxt = UP;
    endcase
  end

  // Idle wait counter: any clear source wins over counting; holds at T_LIMIT.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (Tclear || KeyClean || (state == DOWN)) begin
      wait_cnt <= '0;
    end else if (wait_cnt != T_LIM) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign T = (wait_cnt == T_LIM);

endmodule

// File: tb/tb_morse_key_timer.sv
// Bench for morse_key_timer with a cycle-level behavioural model of the
// key conditioning, press classification and idle timeout.
module tb_morse_key_timer;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned DB_CYCLES = 4;
  localparam int unsigned DOT_MAX   = 10;
  localparam int unsigned T_LIMIT   = 20;

  logic Clk, Reset, Key, Tclear;
  logic S, L, T, KeyHeld;

  morse_key_timer #(
    .CNT_W    (CNT_W),
    .DB_CYCLES(DB_CYCLES),
    .DOT_MAX  (DOT_MAX),
    .T_LIMIT  (T_LIMIT)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Key    (Key),
    .Tclear (Tclear),
    .S      (S),
    .L      (L),
    .T      (T),
    .KeyHeld(KeyHeld)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: key samples delayed through the synchronizer, accepted level,
  // run lengths of the accepted level and of idle (non-clearing) edges.
  logic m_k1, m_k2, m_clean, m_clean_d;
  int   run, m_hi, last_run, idle;
  logic exp_S, exp_L, exp_T, exp_KH;

  task automatic model_reset();
    m_k1 = 0; m_k2 = 0; m_clean = 0; m_clean_d = 0;
    run = 0; m_hi = 0; last_run = 0; idle = 0;
    exp_S = 0; exp_L = 0; exp_T = 0; exp_KH = 0;
  endtask

  // Drive one cycle of inputs, advance the model over the edge, settle.
  task automatic tick(input logic k, input logic tc);
    logic k2pre, clr;
    Key = k;
    Tclear = tc;
    @(posedge Clk);
    k2pre = m_k2;
    m_k2  = m_k1;
    m_k1  = k;
    // Press ended on the previous edge: the finished high run decides dot/dash.
    exp_S = m_clean_d && !m_clean && (last_run <= int'(DOT_MAX));
    exp_L = m_clean_d && !m_clean && (last_run >  int'(DOT_MAX));
    // Idle edges: no Tclear, key not accepted high, press not in progress.
    clr = tc || m_clean || m_clean_d;
    if (clr) idle = 0;
    else if (idle < int'(T_LIMIT)) idle++;
    exp_T = (idle >= int'(T_LIMIT));
    m_clean_d = m_clean;
    if (k2pre != m_clean) run++;
    else run = 0;
    if (run == int'(DB_CYCLES)) begin
      m_clean = k2pre;
      run = 0;
    end
    if (m_clean) m_hi++;
    else if (m_hi != 0) begin
      last_run = m_hi;
      m_hi = 0;
    end
    exp_KH = m_clean;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1; Key = 0; Tclear = 0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    n_tests++;
    if ({S, L, T, KeyHeld} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset: S L T KeyHeld = %b, required 0000", {S, L, T, KeyHeld});
    end
    Reset = 0;
  endtask

  task automatic test_short_press();
    int ns = 0, nl = 0;
    for (int i = 0; i < 40; i++) begin
      tick((i >= 2 && i < 12), 1'b0);
      ns += S; nl += L;
      n_tests++;
      if ({S, L, T, KeyHeld} !== {exp_S, exp_L, exp_T, exp_KH}) begin
        n_fail++;
        $display("FAIL short_press cyc %0d: S L T KeyHeld = %b, required %b", i, {S, L, T, KeyHeld}, {exp_S, exp_L, exp_T, exp_KH});
      end
    end
    n_tests++;
    if (ns !== 1 || nl !== 0) begin
      n_fail++;
      $display("FAIL short_press count: S=%0d L=%0d, required S=1 L=0", ns, nl);
    end
  endtask

  task automatic test_boundary();
    int hold;
    int ns, nl;
    for (int p = 0; p < 2; p++) begin
      hold = 10 + p;
      ns = 0; nl = 0;
      for (int i = 0; i < 40; i++) begin
        tick((i >= 1 && i < 1 + hold), 1'b0);
        ns += S; nl += L;
        n_tests++;
        if ({S, L, T, KeyHeld} !== {exp_S, exp_L, exp_T, exp_KH}) begin
          n_fail++;
          $display("FAIL boundary hold=%0d cyc %0d: S L T KeyHeld = %b, required %b", hold, i, {S, L, T, KeyHeld}, {exp_S, exp_L, exp_T, exp_KH});
        end
      end
      n_tests++;
      if (ns !== (p == 0 ? 1 : 0) || nl !== (p == 0 ? 0 : 1)) begin
        n_fail++;
        $display("FAIL boundary count hold=%0d: S=%0d L=%0d, required S=%0d L=%0d", hold, ns, nl, (p == 0 ? 1 : 0), (p == 0 ? 0 : 1));
      end
    end
  endtask

  task automatic test_bounce();
    int nkh = 0, nl = 0;
    for (int i = 0; i < 36; i++) begin
      tick((i < 30) ? logic'((i / 2) % 2) : 1'b0, 1'b0);
      nkh += KeyHeld;
      n_tests++;
      if ({S, L, T, KeyHeld} !== {exp_S, exp_L, exp_T, exp_KH}) begin
        n_fail++;
        $display("FAIL bounce cyc %0d: S L T KeyHeld = %b, required %b", i, {S, L, T, KeyHeld}, {exp_S, exp_L, exp_T, exp_KH});
      end
    end
    n_tests++;
    if (nkh !== 0) begin
      n_fail++;
      $display("FAIL bounce keyheld: high for %0d cycles, required 0", nkh);
    end
    for (int i = 0; i < 45; i++) begin
      tick((i < 30), 1'b0);
      nl += L;
      n_tests++;
      if ({S, L, T, KeyHeld} !== {exp_S, exp_L, exp_T, exp_KH}) begin
        n_fail++;
        $display("FAIL bounce_press cyc %0d: S L T KeyHeld = %b, required %b", i, {S, L, T, KeyHeld}, {exp_S, exp_L, exp_T, exp_KH});
      end
    end
    n_tests++;
    if (nl !== 1) begin
      n_fail++;
      $display("FAIL bounce_press L count: %0d, required 1", nl);
    end
  endtask

  task automatic test_timeout();
    int nt = 0;
    for (int i = 0; i < 50; i++) begin
      tick((i < 8), 1'b0);
      n_tests++;
      if ({S, L, T, KeyHeld} !== {exp_S, exp_L, exp_T, exp_KH}) begin
        n_fail++;
        $display("FAIL timeout cyc %0d: S L T KeyHeld = %b, required %b", i, {S, L, T, KeyHeld}, {exp_S, exp_L, exp_T, exp_KH});
      end
    end
    n_tests++;
    if (T !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout T_after_idle: T=%b, required 1", T);
    end
    tick(1'b0, 1'b1);
    n_tests++;
    if (T !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout T_after_tclear: T=%b, required 0", T);
    end
    for (int i = 0; i < 25; i++) begin
      tick(1'b0, 1'b0);
      n_tests++;
      if (T !== exp_T) begin
        n_fail++;
        $display("FAIL timeout rearm cyc %0d: T=%b, required %b", i, T, exp_T);
      end
    end
    n_tests++;
    if (T !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout T_rearmed: T=%b, required 1", T);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      if (i >= 6) nt += T;
      n_tests++;
      if ({S, L, T, KeyHeld} !== {exp_S, exp_L, exp_T, exp_KH}) begin
        n_fail++;
        $display("FAIL timeout press cyc %0d: S L T KeyHeld = %b, required %b", i, {S, L, T, KeyHeld}, {exp_S, exp_L, exp_T, exp_KH});
      end
    end
    n_tests++;
    if (nt !== 0) begin
      n_fail++;
      $display("FAIL timeout T_during_press: high %0d cycles, required 0", nt);
    end
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_tclear_held();
    int nt = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b1);
      if (i > 0) nt += T;
    end
    n_tests++;
    if (nt !== 0) begin
      n_fail++;
      $display("FAIL tclear_held: T high %0d cycles, required 0", nt);
    end
  endtask

  task automatic test_reset_mid_press();
    int guard = 0;
    int np = 0;
    while (m_hi != 8 && guard < 60) begin
      tick(1'b1, 1'b0);
      guard++;
    end
    n_tests++;
    if (m_hi != 8) begin
      n_fail++;
      $display("FAIL reset_mid_press wait: press not reached in %0d cycles, required press_cnt 7", guard);
    end
    #2;
    Reset = 1;
    #1;
    n_tests++;
    if ({S, L, T, KeyHeld} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_press async: S L T KeyHeld = %b, required 0000", {S, L, T, KeyHeld});
    end
    Key = 0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 0;
    model_reset();
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0);
      np += S + L;
      n_tests++;
      if ({S, L, T, KeyHeld} !== {exp_S, exp_L, exp_T, exp_KH}) begin
        n_fail++;
        $display("FAIL reset_mid_press after cyc %0d: S L T KeyHeld = %b, required %b", i, {S, L, T, KeyHeld}, {exp_S, exp_L, exp_T, exp_KH});
      end
    end
    n_tests++;
    if (np !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_press pulses: %0d, required 0", np);
    end
  endtask

  task automatic test_random();
    logic lvl = 0;
    int hold;
    int cyc = 0;
    while (cyc < 1500) begin
      lvl  = ~lvl;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
      for (int i = 0; i < hold; i++) begin
        tick(lvl, logic'($urandom_range(0, 15) == 0));
        cyc++;
        n_tests++;
        if ({S, L, T, KeyHeld} !== {exp_S, exp_L, exp_T, exp_KH}) begin
          n_fail++;
          $display("FAIL random cyc %0d: S L T KeyHeld = %b, required %b", cyc, {S, L, T, KeyHeld}, {exp_S, exp_L, exp_T, exp_KH});
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    Reset = 1; Key = 0; Tclear = 0;
    #1;
    test_reset();
    test_short_press();
    test_boundary();
    test_bounce();
    test_timeout();
    test_tclear_held();
    test_reset_mid_press();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_key_timer.md
# morse_key_timer

Front-end stage of the Morse decoder: conditions the raw push-button `Key`, measures each press, and emits one-cycle `S` (dot) or `L` (dash) pulses on release. It also runs the inter-symbol wait counter that raises `T` when the user has been idle too long. Its outputs drive the `L`, `S` and `T` inputs of the letter state machine directly, and it consumes that machine's `Tclear` output.

## Interface
- `CNT_W`, 27, width of the press and wait counters.
- `DB_CYCLES`, 500000, number of consecutive stable synchronized samples needed to accept a key level change (5 ms at 100 MHz).
- `DOT_MAX`, 25000000, longest press still classified as a dot; `press_cnt <= DOT_MAX` gives S, otherwise L.
- `T_LIMIT`, 75000000, idle cycles after which T asserts.
- `Clk  in  1  system clock`
- `Reset  in  1  asynchronous, active-high; clears all state`
- `Key  in  1  raw, asynchronous, bouncing button, active-high`
- `Tclear  in  1  wait-counter clear from the letter state machine, active-high, level`
- `S  out  1  one-cycle pulse: a dot press was completed`
- `L  out  1  one-cycle pulse: a dash press was completed`
- `T  out  1  level: idle wait has reached T_LIMIT`
- `KeyHeld  out  1  debounced key level, for the LED`

## Operation
- **Synchronizer:** 2-flop chain `Key -> k1 -> k2`.
- **Debouncer:**
  - `db_cnt` (width `CNT_W`) clears whenever `k2 == KeyClean`.
  - Otherwise it increments each cycle.
  - When it reaches `DB_CYCLES - 1` while `k2 != KeyClean`: `KeyClean <= k2` and `db_cnt <= 0`.
  - `KeyHeld = KeyClean`.
- **Press FSM**, states UP and DOWN:
  - UP, `KeyClean = 1`: go to DOWN, `press_cnt <= 1`.
  - UP, `KeyClean = 0`: stay in UP.
  - DOWN, `KeyClean = 1`: `press_cnt` increments, saturating at all-ones.
  - DOWN, `KeyClean = 0`: go to UP. Set `S <= 1` if `press_cnt <= DOT_MAX`, else `L <= 1`.
  - S and L are registered, high for exactly one cycle, and never high together.
- **Wait counter** `wait_cnt`:
  - Clears to 0 if `Tclear == 1`, or `KeyClean == 1`, or the state is DOWN.
  - Otherwise increments until it equals `T_LIMIT`, then holds.
  - `T = (wait_cnt == T_LIMIT)`, decoded from the register.
  - Clearing has priority over incrementing.
  - T therefore never asserts during a press, and drops the cycle after `Tclear` or a press is seen.
- **No Start gating:** the block runs continuously. The letter state machine ignores the pulses when it is not started.

## Timing
- **Reset values:** S=0, L=0, T=0, KeyHeld=0, state UP, all counters 0, k1=k2=0.
- **Reset mid-press:** no pulse is emitted. After release of Reset the block behaves as if the key were up, and a still-held key is re-debounced as a new press.
- **Key-to-KeyHeld latency:** 2 synchronizer cycles plus `DB_CYCLES` stable cycles. This applies to both edges.
- **Release-to-pulse latency:** S/L rises 1 cycle after KeyClean falls.
- **Press classification boundary:** `press_cnt` equals the number of cycles KeyClean was high. Exactly `DOT_MAX` cycles gives S; `DOT_MAX + 1` gives L.
- **Glitch rejection:** bounces shorter than `DB_CYCLES` produce no KeyClean change and no pulse.
- **Wait-counter timing:**
  - After KeyClean falls, `wait_cnt` starts counting in the cycle after the FSM returns to UP, provided `Tclear = 0`.
  - T asserts `T_LIMIT` increments later.
- **Simultaneous `Tclear` and T:** `Tclear` wins; T deasserts on the next cycle.
- **Saturation:**
  - `press_cnt` saturation only affects presses longer than `2^CNT_W - 1` cycles, which still yield L.
  - `wait_cnt` never wraps.

## Test plan
Benches override the parameters to `DB_CYCLES=4`, `DOT_MAX=10`, `T_LIMIT=20`, `CNT_W=8`, with `Tclear` tied low unless stated.
- **Clean short press:** hold Key for 10 debounced cycles -> exactly one S pulse 1 cycle after KeyHeld falls; L stays 0.
- **Classification boundary:** press giving `press_cnt = 10` -> S; press giving `press_cnt = 11` -> L. Each pulse is 1 cycle wide.
- **Bounce:** Key toggling every 2 cycles for 30 cycles then low -> KeyHeld stays 0, no S/L. Then a stable press of 30 cycles -> one L.
- **Timeout:**
  - After an S pulse, Key low -> T rises 20 cycles after counting starts and holds.
  - Pulse `Tclear` for 1 cycle -> T low next cycle and rises again 20 cycles later.
  - Pressing Key -> T low, stays low while the key is held.
- **Tclear held high:** `wait_cnt` stays 0 and T never asserts over 100 cycles.
- **Reset mid-press:** assert Reset while DOWN with `press_cnt = 7` -> all outputs 0 immediately, no S/L on the subsequent release.
